pipelined_prefix_sum: RTL and testbench
=======================================

# pipelined_prefix_sum

Parametrised, pipelined Ladner-Fischer prefix-sum unit over a LANES-bit mask, with valid/ready handshakes, selectable inclusive or exclusive mode per beat, and running-count chaining across multi-beat frames. It is the next generation of the 128-lane combinational prefix-sum adder. It feeds compaction and redundancy-index logic that needs per-lane write offsets for masks wider than one beat.

## Interface
- LANES, 128: mask width per beat. Must be a power of two, at least 2.
- CNT_W, 16: width of each prefix count and of the running total. Must be at least clog2(LANES)+1.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_mask  in  LANES  mask bits; lane 0 is the LSB.
- in_mode  in  1  0 = inclusive, 1 = exclusive; sampled with the beat.
- in_last  in  1  beat closes the current frame.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- out_psum  out  LANES*CNT_W  lane i occupies bits [i*CNT_W +: CNT_W].
- out_total  out  CNT_W  running count through this beat: base plus popcount.
- out_last  out  1  in_last carried through with the beat.
- out_ovf  out  1  running count has wrapped at least once in this frame.

## Operation
- A beat transfers on in_valid && in_ready. An output beat transfers on out_valid && out_ready.
- Inclusive mode: out_psum[i] = base + popcount(mask[i:0]).
- Exclusive mode: out_psum[i] = base + popcount(mask[i-1:0]). Lane 0 equals base.
- base is the running count of all earlier beats in the same frame. It is 0 for the first beat of a frame.
- The pipeline has LVL = clog2(LANES) Ladner-Fischer levels. Each level is followed by a register, and valid, mode and last travel alongside the data.
- A final output stage adds base_r to every lane count and to the beat popcount, then registers the result.
- base_r updates when a beat moves into the output register:
  - in_last set: base_r becomes 0 and the overflow flag clears.
  - otherwise: base_r becomes base_r + popcount, modulo 2^CNT_W.
- Beats never reorder, so base_r always belongs to the beat entering the output stage.
- All sums are modulo 2^CNT_W.
- out_ovf is set when any base + popcount sum in the frame, including the current beat, reaches 2^CNT_W or more. It stays set through the beat marked out_last.
- Stall rule: the whole pipeline advances only when !out_valid || out_ready. in_ready equals that same condition.
- Bubbles propagate as invalid stages. No state machine beyond the per-stage valid bits, base_r and the overflow flag.
- Reset: all valid bits 0, base_r 0, overflow flag 0.
  - Outputs after reset: out_valid 0, out_psum 0, out_total 0, out_last 0, out_ovf 0. in_ready is 1 once reset_n deasserts.
  - A reset in mid-frame discards every beat in flight. The next accepted beat starts a new frame.

## Timing
- Latency: a beat accepted at edge k gives out_valid after edge k+LVL+1 when there is no back-pressure. For LANES=128 that is 8 cycles.
- Throughput is one beat per cycle while out_ready stays high.
- in_ready is combinational from out_valid and out_ready. No other input-to-output combinational path exists.
- While out_valid=1 and out_ready=0, every output holds stable and no internal register changes.
- in_mode and in_last are honoured per beat. Mixing modes within a frame is legal, and base accumulates popcount in both modes.

## Structure
- Package prefix_sum_pkg holds:
  - a clog2 function;
  - MODE_INCL = 0 and MODE_EXCL = 1;
  - a helper giving the LF level's partner index.
- Sub-module lf_prefix_level (parameters LANES, CNT_W, LEVEL): one registered Ladner-Fischer level with a stall enable. It is instantiated LVL times in a generate loop.
- The top level holds the handshake, base_r, the overflow flag and the output adder stage.

## Test plan
- LANES=128, inclusive, mask all ones, in_last=1, out_ready=1: after 8 cycles out_psum[i]=i+1, out_total=128, out_ovf=0.
- Exclusive, mask=0x13, in_last=1: out_psum[0]=0, [1]=1, [2..4]=2, [5..127]=3, out_total=3.
- Chaining: two all-ones beats, the second with in_last=1, then a third all-ones beat: second beat out_psum[0]=129 and out_total=256; third beat out_psum[0]=1 (new frame).
- Back-pressure: fill the pipeline, hold out_ready=0 for 5 cycles: in_ready=0, outputs stable, and all beats later emerge once, in order, with correct bases.
- Overflow with LANES=8, CNT_W=4, three all-ones beats, the last with in_last=1:
  - beat totals are 8, 0 (ovf=1) and 8 (ovf=1);
  - a following frame shows ovf=0.
- Reset mid-frame with 3 beats in flight: out_valid=0 immediately; the next all-ones beat gives out_psum[0]=1 and out_total=128.

Source files
------------

// File: rtl/prefix_sum_pkg.sv
// Shared definitions for the pipelined Ladner-Fischer prefix-sum unit:
// beat mode encodings and elaboration-time helpers for sizing and wiring.
package prefix_sum_pkg;

  localparam logic MODE_INCL = 1'b0;
  localparam logic MODE_EXCL = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // A lane adds in a partner at a level when that level's index bit is set;
  // the partner is the last lane of the preceding block of 2^level lanes.
  function automatic bit lf_active(input int lane, input int level);
    return ((lane >> level) & 1) != 0;
  endfunction

  function automatic int lf_partner(input int lane, input int level);
    return ((lane >> level) << level) - 1;
  endfunction

endpackage

// File: rtl/pipelined_prefix_sum_level.sv
// One registered Ladner-Fischer prefix level; the register only loads when
// the whole pipeline is allowed to advance.
module lf_prefix_level
  import prefix_sum_pkg::*;
#(
  parameter int LANES = 128,
  parameter int CNT_W = 16,
  parameter int LEVEL = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic                   in_mode,
  input  logic                   in_last,
  input  logic [LANES*CNT_W-1:0] in_cnt,
  output logic                   out_valid,
  output logic                   out_mode,
  output logic                   out_last,
  output logic [LANES*CNT_W-1:0] out_cnt
);

  logic [LANES*CNT_W-1:0] nxt_cnt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (lf_active(i, LEVEL)) begin : g_add
      assign nxt_cnt[i*CNT_W +: CNT_W] = in_cnt[i*CNT_W +: CNT_W]
                                       + in_cnt[lf_partner(i, LEVEL)*CNT_W +: CNT_W];
    end else begin : g_pass
      assign nxt_cnt[i*CNT_W +: CNT_W] = in_cnt[i*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_last  <= 1'b0;
      out_cnt   <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_last  <= in_last;
      out_cnt   <= nxt_cnt;
    end
  end

endmodule

// File: rtl/pipelined_prefix_sum.sv
// Pipelined prefix-sum over a LANES-bit mask with per-beat inclusive/exclusive
// mode and a running base that chains counts across the beats of a frame.
module pipelined_prefix_sum
  import prefix_sum_pkg::*;
#(
  parameter int LANES = 128,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES-1:0]       in_mask,
  input  logic                   in_mode,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*CNT_W-1:0] out_psum,
  output logic [CNT_W-1:0]       out_total,
  output logic                   out_last,
  output logic                   out_ovf
);

  localparam int LVL = clog2(LANES);

  logic                   advance;
  logic                   stg_valid [LVL+1];
  logic                   stg_mode  [LVL+1];
  logic                   stg_last  [LVL+1];
  logic [LANES*CNT_W-1:0] stg_cnt   [LVL+1];
  logic [LANES*CNT_W-1:0] mask_cnt;

  logic [CNT_W-1:0]       base_r;
  logic                   ovf_r;
  logic                   valid_r;
  logic                   last_r;
  logic                   ovf_out_r;
  logic [CNT_W-1:0]       total_r;
  logic [LANES*CNT_W-1:0] psum_r;

  logic [CNT_W-1:0]       pop;
  logic [CNT_W:0]         total_sum;
  logic [LANES*CNT_W-1:0] psum_nxt;

  assign advance  = !valid_r || out_ready;
  assign in_ready = advance;

  always_comb begin
    mask_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      mask_cnt[i*CNT_W +: CNT_W] = CNT_W'(in_mask[i]);
    end
  end

  assign stg_valid[0] = in_valid;
  assign stg_mode[0]  = in_mode;
  assign stg_last[0]  = in_last;
  assign stg_cnt[0]   = mask_cnt;

  for (genvar l = 0; l < LVL; l++) begin : g_level
    lf_prefix_level #(
      .LANES(LANES),
      .CNT_W(CNT_W),
      .LEVEL(l)
    ) u_level (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (advance),
      .in_valid (stg_valid[l]),
      .in_mode  (stg_mode[l]),
      .in_last  (stg_last[l]),
      .in_cnt   (stg_cnt[l]),
      .out_valid(stg_valid[l+1]),
      .out_mode (stg_mode[l+1]),
      .out_last (stg_last[l+1]),
      .out_cnt  (stg_cnt[l+1])
    );
  end

  // The top lane of the inclusive scan is the beat popcount; its carry into
  // bit CNT_W is the only way any lane of this beat can wrap.
  assign pop       = stg_cnt[LVL][(LANES-1)*CNT_W +: CNT_W];
  assign total_sum = {1'b0, base_r} + {1'b0, pop};

  for (genvar i = 0; i < LANES; i++) begin : g_out
    logic [CNT_W-1:0] incl_cnt;
    logic [CNT_W-1:0] excl_cnt;
    assign incl_cnt = stg_cnt[LVL][i*CNT_W +: CNT_W];
    if (i == 0) begin : g_first
      assign excl_cnt = '0;
    end else begin : g_rest
      assign excl_cnt = stg_cnt[LVL][(i-1)*CNT_W +: CNT_W];
    end
    assign psum_nxt[i*CNT_W +: CNT_W] = base_r + ((stg_mode[LVL] == MODE_EXCL) ? excl_cnt : incl_cnt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r   <= 1'b0;
      psum_r    <= '0;
      total_r   <= '0;
      last_r    <= 1'b0;
      ovf_out_r <= 1'b0;
      base_r    <= '0;
      ovf_r     <= 1'b0;
    end else if (advance) begin
      valid_r <= stg_valid[LVL];
      if (stg_valid[LVL]) begin
        psum_r    <= psum_nxt;
        total_r   <= total_sum[CNT_W-1:0];
        last_r    <= stg_last[LVL];
        ovf_out_r <= ovf_r | total_sum[CNT_W];
        if (stg_last[LVL]) begin
          base_r <= '0;
          ovf_r  <= 1'b0;
        end else begin
          base_r <= total_sum[CNT_W-1:0];
          ovf_r  <= ovf_r | total_sum[CNT_W];
        end
      end
    end
  end

  assign out_valid = valid_r;
  assign out_psum  = psum_r;
  assign out_total = total_r;
  assign out_last  = last_r;
  assign out_ovf   = ovf_out_r;

endmodule

// File: tb/tb_pipelined_prefix_sum.sv
// Bench for pipelined_prefix_sum: a 128x16 instance and an 8x4 instance checked
// against a frame-level running-count model plus directed literal expectations.
module tb_pipelined_prefix_sum;
  import prefix_sum_pkg::*;

  localparam int BL = 128;
  localparam int BW = 16;
  localparam int SL = 8;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic out_ready;
  always #5 clk = ~clk;

  logic            b_in_valid, b_in_ready, b_in_mode, b_in_last;
  logic [BL-1:0]   b_in_mask;
  logic            b_out_valid, b_out_last, b_out_ovf;
  logic [BL*BW-1:0] b_out_psum;
  logic [BW-1:0]   b_out_total;

  logic            s_in_valid, s_in_ready, s_in_mode, s_in_last;
  logic [SL-1:0]   s_in_mask;
  logic            s_out_valid, s_out_last, s_out_ovf;
  logic [SL*SW-1:0] s_out_psum;
  logic [SW-1:0]   s_out_total;

  pipelined_prefix_sum #(.LANES(BL), .CNT_W(BW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mask(b_in_mask),
    .in_mode(b_in_mode), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_psum(b_out_psum),
    .out_total(b_out_total), .out_last(b_out_last), .out_ovf(b_out_ovf)
  );

  pipelined_prefix_sum #(.LANES(SL), .CNT_W(SW)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_mask(s_in_mask),
    .in_mode(s_in_mode), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_psum(s_out_psum),
    .out_total(s_out_total), .out_last(s_out_last), .out_ovf(s_out_ovf)
  );

  typedef struct packed {
    logic [127:0] mask;
    logic         mode;
    logic         last;
    logic [31:0]  base;
    logic [31:0]  total;
    logic         ovf;
  } exp_t;

  exp_t   q_b[$];
  exp_t   q_s[$];
  longint run_b = 0;
  longint run_s = 0;
  int     n_compared = 0;
  int     n_mismatched = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Frame model: the unwrapped running count decides base, total and overflow.
  task automatic modelAccept(input logic [127:0] m, input logic mode, input logic last,
                             input int lanes, input int w, input longint run_in,
                             output longint run_out, output exp_t e);
    longint pop;
    longint modv;
    pop = 0;
    for (int k = 0; k < lanes; k++) if (m[k]) pop++;
    modv    = longint'(1) << w;
    e.mask  = m;
    e.mode  = mode;
    e.last  = last;
    e.base  = 32'(run_in % modv);
    e.total = 32'((run_in + pop) % modv);
    e.ovf   = (run_in + pop) >= modv;
    run_out = last ? 0 : run_in + pop;
  endtask

  task automatic checkBeat(input string tag, input exp_t e, input logic [2047:0] psum,
                           input int lanes, input int w, input longint total,
                           input logic last, input logic ovf);
    int c, excl, cnt, expv, gotv, bad_lane, bad_exp, bad_got;
    logic [2047:0] sh;
    c = 0;
    bad_lane = -1;
    bad_exp = 0;
    bad_got = 0;
    for (int i = 0; i < lanes; i++) begin
      excl = c;
      if (e.mask[i]) c++;
      cnt  = (e.mode == MODE_EXCL) ? excl : c;
      expv = (int'(e.base) + cnt) % (1 << w);
      sh   = psum >> (i * w);
      gotv = int'(sh[31:0]) & ((1 << w) - 1);
      if (gotv != expv && bad_lane < 0) begin
        bad_lane = i;
        bad_exp  = expv;
        bad_got  = gotv;
      end
    end
    n_compared++;
    if (bad_lane >= 0) begin
      n_mismatched++;
      $display("[TB] FAIL %s psum lane %0d: got %0d, expected %0d", tag, bad_lane, bad_got, bad_exp);
    end
    checkOutput({tag, " total"}, total, longint'(e.total));
    checkOutput({tag, " last"}, longint'(last), longint'(e.last));
    checkOutput({tag, " ovf"}, longint'(ovf), longint'(e.ovf));
  endtask

  // Single compare process: checks every presented output beat and records accepted beats.
  always @(negedge clk) begin
    exp_t   e;
    longint nrun;
    if (!reset_n) begin
      q_b.delete();
      q_s.delete();
      run_b = 0;
      run_s = 0;
    end else begin
      checkOutput("big in_ready rule", longint'(b_in_ready), longint'(!b_out_valid || out_ready));
      checkOutput("small in_ready rule", longint'(s_in_ready), longint'(!s_out_valid || out_ready));
      if (b_out_valid) begin
        if (q_b.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL big spurious beat: out_valid got 1, expected 0");
        end else begin
          checkBeat("big", q_b[0], b_out_psum, BL, BW, longint'(b_out_total), b_out_last, b_out_ovf);
          if (out_ready) void'(q_b.pop_front());
        end
      end
      if (s_out_valid) begin
        if (q_s.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL small spurious beat: out_valid got 1, expected 0");
        end else begin
          checkBeat("small", q_s[0], 2048'(s_out_psum), SL, SW, longint'(s_out_total), s_out_last, s_out_ovf);
          if (out_ready) void'(q_s.pop_front());
        end
      end
      if (b_in_valid && b_in_ready) begin
        modelAccept(b_in_mask, b_in_mode, b_in_last, BL, BW, run_b, nrun, e);
        run_b = nrun;
        q_b.push_back(e);
      end
      if (s_in_valid && s_in_ready) begin
        modelAccept(128'(s_in_mask), s_in_mode, s_in_last, SL, SW, run_s, nrun, e);
        run_s = nrun;
        q_s.push_back(e);
      end
    end
  end

  // Presents one beat (called just after a rising edge) and holds it until accepted.
  task automatic applyStimulus(input bit big, input logic [127:0] m, input logic mode, input logic last);
    bit accepted;
    accepted = 1'b0;
    if (big) begin
      b_in_valid = 1'b1; b_in_mask = m; b_in_mode = mode; b_in_last = last;
    end else begin
      s_in_valid = 1'b1; s_in_mask = m[SL-1:0]; s_in_mode = mode; s_in_last = last;
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (big ? b_in_ready : s_in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (big) b_in_valid = 1'b0;
    else     s_in_valid = 1'b0;
    if (!accepted) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL accept timeout: in_ready got 0, expected 1");
    end
  endtask

  task automatic waitOut(input bit big, input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (big ? b_out_valid : s_out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s timeout: out_valid got 0, expected 1", name);
    end
  endtask

  task automatic bLane(input string name, input int lane, input longint expected);
    checkOutput(name, longint'(b_out_psum[lane*BW +: BW]), expected);
  endtask

  initial begin
    int lat;
    logic [BL*BW-1:0] snap;
    logic [BW-1:0] snap_total;

    out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_mask = '0; b_in_mode = 1'b0; b_in_last = 1'b0;
    s_in_valid = 1'b0; s_in_mask = '0; s_in_mode = 1'b0; s_in_last = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", longint'(b_out_valid), 0);
    checkOutput("reset psum nonzero", longint'(b_out_psum != '0), 0);
    checkOutput("reset total", longint'(b_out_total), 0);
    checkOutput("reset last", longint'(b_out_last), 0);
    checkOutput("reset ovf", longint'(b_out_ovf), 0);
    checkOutput("reset small out_valid", longint'(s_out_valid), 0);
    reset_n = 1'b1;
    #1;
    checkOutput("in_ready after reset", longint'(b_in_ready), 1);
    @(posedge clk);
    #1;

    $display("[TB] inclusive all-ones beat and latency");
    applyStimulus(1'b1, {128{1'b1}}, MODE_INCL, 1'b1);
    lat = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b_out_valid) break;
      lat++;
    end
    checkOutput("latency", lat, 8);
    bLane("incl lane0", 0, 1);
    bLane("incl lane63", 63, 64);
    bLane("incl lane127", 127, 128);
    checkOutput("incl total", longint'(b_out_total), 128);
    checkOutput("incl ovf", longint'(b_out_ovf), 0);
    checkOutput("incl last", longint'(b_out_last), 1);
    @(posedge clk);
    #1;

    $display("[TB] exclusive mask 0x13");
    applyStimulus(1'b1, 128'h13, MODE_EXCL, 1'b1);
    waitOut(1'b1, "excl");
    bLane("excl lane0", 0, 0);
    bLane("excl lane1", 1, 1);
    bLane("excl lane2", 2, 2);
    bLane("excl lane4", 4, 2);
    bLane("excl lane5", 5, 3);
    bLane("excl lane127", 127, 3);
    checkOutput("excl total", longint'(b_out_total), 3);
    @(posedge clk);
    #1;

    $display("[TB] chaining across beats and frames");
    applyStimulus(1'b1, {128{1'b1}}, MODE_INCL, 1'b0);
    applyStimulus(1'b1, {128{1'b1}}, MODE_INCL, 1'b1);
    applyStimulus(1'b1, {128{1'b1}}, MODE_INCL, 1'b1);
    waitOut(1'b1, "chain beat1");
    checkOutput("chain1 total", longint'(b_out_total), 128);
    @(negedge clk);
    checkOutput("chain2 valid", longint'(b_out_valid), 1);
    bLane("chain2 lane0", 0, 129);
    checkOutput("chain2 total", longint'(b_out_total), 256);
    @(negedge clk);
    checkOutput("chain3 valid", longint'(b_out_valid), 1);
    bLane("chain3 lane0", 0, 1);
    checkOutput("chain3 total", longint'(b_out_total), 128);
    @(posedge clk);
    #1;

    $display("[TB] back-pressure");
    applyStimulus(1'b1, 128'hFFFF, MODE_INCL, 1'b0);
    applyStimulus(1'b1, 128'h1 << 100, MODE_EXCL, 1'b0);
    applyStimulus(1'b1, {32{4'hA}}, MODE_INCL, 1'b0);
    applyStimulus(1'b1, 128'h0, MODE_EXCL, 1'b0);
    applyStimulus(1'b1, {16{8'hF0}}, MODE_EXCL, 1'b0);
    applyStimulus(1'b1, {128{1'b1}}, MODE_INCL, 1'b1);
    waitOut(1'b1, "bp first");
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_mask = 128'h8000_0000_0000_0000_0000_0000_0000_0007;
    b_in_mode = MODE_INCL; b_in_last = 1'b1;
    snap = b_out_psum;
    snap_total = b_out_total;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall in_ready", longint'(b_in_ready), 0);
      checkOutput("stall out_valid", longint'(b_out_valid), 1);
      checkOutput("stall psum changed", longint'(b_out_psum != snap), 0);
      checkOutput("stall total", longint'(b_out_total), longint'(snap_total));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    for (int c = 0; c < 40 && q_b.size() != 0; c++) @(posedge clk);
    #1;
    checkOutput("bp drained", q_b.size(), 0);

    $display("[TB] overflow on 8-lane 4-bit instance");
    applyStimulus(1'b0, 128'hFF, MODE_INCL, 1'b0);
    applyStimulus(1'b0, 128'hFF, MODE_INCL, 1'b0);
    applyStimulus(1'b0, 128'hFF, MODE_INCL, 1'b1);
    applyStimulus(1'b0, 128'hFF, MODE_INCL, 1'b1);
    waitOut(1'b0, "ovf beat1");
    checkOutput("ovf1 total", longint'(s_out_total), 8);
    checkOutput("ovf1 flag", longint'(s_out_ovf), 0);
    @(negedge clk);
    checkOutput("ovf2 total", longint'(s_out_total), 0);
    checkOutput("ovf2 flag", longint'(s_out_ovf), 1);
    checkOutput("ovf2 lane0", longint'(s_out_psum[3:0]), 9);
    @(negedge clk);
    checkOutput("ovf3 total", longint'(s_out_total), 8);
    checkOutput("ovf3 flag", longint'(s_out_ovf), 1);
    checkOutput("ovf3 last", longint'(s_out_last), 1);
    @(negedge clk);
    checkOutput("ovf4 total", longint'(s_out_total), 8);
    checkOutput("ovf4 flag", longint'(s_out_ovf), 0);
    @(posedge clk);
    #1;

    $display("[TB] reset in mid-frame");
    out_ready = 1'b0;
    applyStimulus(1'b1, {128{1'b1}}, MODE_INCL, 1'b0);
    applyStimulus(1'b1, 128'h5, MODE_INCL, 1'b0);
    applyStimulus(1'b1, 128'h3, MODE_EXCL, 1'b0);
    waitOut(1'b1, "pre-reset");
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", longint'(b_out_valid), 0);
    checkOutput("midreset psum nonzero", longint'(b_out_psum != '0), 0);
    checkOutput("midreset total", longint'(b_out_total), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, {128{1'b1}}, MODE_INCL, 1'b1);
    waitOut(1'b1, "post-reset");
    bLane("postreset lane0", 0, 1);
    checkOutput("postreset total", longint'(b_out_total), 128);
    checkOutput("postreset ovf", longint'(b_out_ovf), 0);

    for (int c = 0; c < 40 && (q_b.size() != 0 || q_s.size() != 0); c++) @(posedge clk);
    #1;
    checkOutput("final drain", q_b.size() + q_s.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time got 200000, expected less");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
